uart_tx: RTL and testbench

UART transmitter and counterpart to the oversampling receiver on the same link.
- Serializes bytes into 8N1 frames, each bit held exactly CLKS_PER_BIT clk cycles (16x oversampled line clock).
- Sits between the host-side byte source (valid/ready) and the serial pin.
- A one-entry holding register lets back-to-back frames go out with no idle gap.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tx_baud_tick.sv | 30 +++
 rtl/uart_tx.sv | 187 ++++++++++++++++++
 tb/tb_uart_tx.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and state type for the UART transmitter.
// The state list includes PARITY; it is only reachable when UART_TX_PARITY_EN is defined.
package uart_pkg;

   localparam int   CLKS_PER_BIT_DEF = 16;
   localparam int   DATA_BITS_DEF    = 8;
   localparam logic LINE_IDLE        = 1'b1;

   typedef enum logic [2:0] {
      GUARD,
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

endpackage

// File: rtl/uart_tx_baud_tick.sv
// Bit-period timer: down-counter from CLKS_PER_BIT-1 to 0 with terminal-count flag.
// It reloads on wrap and whenever restart is high.
module uart_baud_tick #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   output logic bit_end
);

   localparam int            CW     = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] r_cnt;

   // Reset counts as entry into GUARD, so the first bit period starts fully loaded.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= RELOAD;
      end else if (restart || (r_cnt == '0)) begin
         r_cnt <= RELOAD;
      end else begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign bit_end = (r_cnt == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8N1 framing with a one-entry holding register for gapless back-to-back frames.
// Optional parity bit is enabled by defining UART_TX_PARITY_EN (adds parameter PARITY_ODD).
//
// state  | meaning
// GUARD  | line held high for one bit time after reset release
// IDLE   | line high, waiting for the holding register to fill
// START  | start bit (low)
// DATA   | payload bits, LSB first
// PARITY | parity bit (only with UART_TX_PARITY_EN)
// STOP   | stop bit(s) (high); reloads directly from hold when full
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int DATA_BITS    = DATA_BITS_DEF,
   parameter int STOP_BITS    = 1
`ifdef UART_TX_PARITY_EN
   ,
   parameter bit PARITY_ODD   = 1'b0
`endif
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   input  logic [DATA_BITS-1:0] in_data,
   output logic                 in_ready,
   output logic                 tx,
   output logic                 tx_busy,
   output logic                 tx_done
);

   localparam int            IW        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);
   localparam logic          STOP_LAST = (STOP_BITS > 1) ? 1'b1 : 1'b0;

   tx_state_t            r_state, w_state_nxt;
   logic                 r_tx, w_tx_nxt;
   logic                 r_tx_done, w_done_nxt;
   logic [DATA_BITS-1:0] r_hold;
   logic                 r_hold_full;
   logic [DATA_BITS-1:0] r_shift, w_shift_nxt, w_shift_sh;
   logic [IW-1:0]        r_bit_idx, w_bit_idx_nxt;
   logic                 r_stop_idx, w_stop_idx_nxt;
   logic                 w_load, w_accept, w_restart, w_bit_end;
`ifdef UART_TX_PARITY_EN
   logic                 r_parity;
`endif

   uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud_tick (
      .clk     (clk),
      .reset   (reset),
      .restart (w_restart),
      .bit_end (w_bit_end)
   );

   assign w_accept   = in_valid & ~r_hold_full;
   assign w_shift_sh = r_shift >> 1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= GUARD;
         r_tx       <= LINE_IDLE;
         r_tx_done  <= 1'b0;
         r_shift    <= '0;
         r_bit_idx  <= '0;
         r_stop_idx <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_tx       <= w_tx_nxt;
         r_tx_done  <= w_done_nxt;
         r_shift    <= w_shift_nxt;
         r_bit_idx  <= w_bit_idx_nxt;
         r_stop_idx <= w_stop_idx_nxt;
      end
   end

   // Accept and load are mutually exclusive: one needs hold empty, the other hold full.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hold      <= '0;
         r_hold_full <= 1'b0;
      end else if (w_accept) begin
         r_hold      <= in_data;
         r_hold_full <= 1'b1;
      end else if (w_load) begin
         r_hold_full <= 1'b0;
      end
   end

`ifdef UART_TX_PARITY_EN
   // Parity is taken from the byte as loaded, since the shift register is consumed during DATA.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_parity <= 1'b0;
      end else if (w_load) begin
         r_parity <= (^r_hold) ^ PARITY_ODD;
      end
   end
`endif

   always_comb begin
      w_state_nxt    = r_state;
      w_tx_nxt       = r_tx;
      w_done_nxt     = 1'b0;
      w_shift_nxt    = r_shift;
      w_bit_idx_nxt  = r_bit_idx;
      w_stop_idx_nxt = r_stop_idx;
      w_load         = 1'b0;
      w_restart      = 1'b0;
      case (r_state)
         GUARD: begin
            if (w_bit_end) w_state_nxt = IDLE;
         end
         IDLE: begin
            w_restart = 1'b1;
            if (r_hold_full) begin
               w_load      = 1'b1;
               w_shift_nxt = r_hold;
               w_tx_nxt    = 1'b0;
               w_state_nxt = START;
            end
         end
         START: begin
            if (w_bit_end) begin
               w_tx_nxt      = r_shift[0];
               w_bit_idx_nxt = '0;
               w_state_nxt   = DATA;
            end
         end
         DATA: begin
            if (w_bit_end) begin
               if (r_bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                  w_tx_nxt       = r_parity;
                  w_state_nxt    = PARITY;
`else
                  w_tx_nxt       = LINE_IDLE;
                  w_stop_idx_nxt = 1'b0;
                  w_state_nxt    = STOP;
`endif
               end else begin
                  w_shift_nxt   = w_shift_sh;
                  w_tx_nxt      = w_shift_sh[0];
                  w_bit_idx_nxt = r_bit_idx + 1'b1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (w_bit_end) begin
               w_tx_nxt       = LINE_IDLE;
               w_stop_idx_nxt = 1'b0;
               w_state_nxt    = STOP;
            end
         end
`endif
         STOP: begin
            if (w_bit_end) begin
               if (r_stop_idx == STOP_LAST) begin
                  w_done_nxt = 1'b1;
                  if (r_hold_full) begin
                     w_load      = 1'b1;
                     w_shift_nxt = r_hold;
                     w_tx_nxt    = 1'b0;
                     w_state_nxt = START;
                  end else begin
                     w_tx_nxt    = LINE_IDLE;
                     w_state_nxt = IDLE;
                  end
               end else begin
                  w_stop_idx_nxt = r_stop_idx + 1'b1;
               end
            end
         end
         default: begin
            w_tx_nxt    = LINE_IDLE;
            w_state_nxt = GUARD;
         end
      endcase
   end

   assign in_ready = ~r_hold_full;
   assign tx       = r_tx;
   assign tx_busy  = (r_state != IDLE);
   assign tx_done  = r_tx_done;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a scoreboard queue of accepted bytes, checked by a
// line-level receiver model that decodes frames from tx and verifies bit timing and tx_done.
module tb_uart_tx;

   localparam int CPB  = 16;
   localparam int STOP = 1;
`ifdef UART_TX_PARITY_EN
   localparam int PBIT = 1;
   localparam bit PODD = 1'b0;
`else
   localparam int PBIT = 0;
`endif
   localparam int NBITS = 1 + 8 + PBIT + STOP;
   localparam int FRAME = NBITS * CPB;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_ready, tx, tx_busy, tx_done;

   uart_tx #(
      .CLKS_PER_BIT (CPB),
      .DATA_BITS    (8),
      .STOP_BITS    (STOP)
`ifdef UART_TX_PARITY_EN
      ,
      .PARITY_ODD   (PODD)
`endif
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .tx       (tx),
      .tx_busy  (tx_busy),
      .tx_done  (tx_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   logic [7:0] exp_q[$];
   logic [7:0] drv_q[$];
   int acc_cyc = 0;

   // Receiver / monitor state
   bit   in_frame = 1'b0;
   int   t0 = 0, last_t0 = 0, last_end = -100000, last_gap = 0;
   int   frames_started = 0, frames_done = 0, done_due = -1, line_err = 0;
   logic fbits[0:15];
   logic smp[0:15];
   logic [7:0] cur_exp;

   always @(negedge clk) begin
      int pos, b, k;
      logic [7:0] dec;
      if (!reset) begin
         in_frame = 1'b0;
         done_due = -1;
         exp_q.delete();
      end else begin
         if (cyc == done_due) begin
            chk("tx_done_pulse", tx_done, 1'b1);
            done_due = -1;
         end else if (tx_done !== 1'b0) begin
            chk("tx_done_spurious", tx_done, 1'b0);
         end
         if (in_frame) begin
            pos = cyc - t0;
            b   = pos / CPB;
            if (tx !== fbits[b]) line_err++;
            if (pos % CPB == CPB / 2) smp[b] = tx;
            if (pos == FRAME - 1) begin
               for (int i = 0; i < 8; i++) dec[i] = smp[1 + i];
               chk("frame_byte", dec, cur_exp);
               chk("frame_line_shape", line_err, 0);
               in_frame = 1'b0;
               done_due = cyc + 1;
               last_end = cyc + 1;
               frames_done++;
            end
         end else if (tx === 1'b0) begin
            t0       = cyc;
            last_t0  = cyc;
            last_gap = cyc - last_end;
            in_frame = 1'b1;
            line_err = 0;
            frames_started++;
            if (exp_q.size() == 0) begin
               chk("unexpected_frame", exp_q.size(), 1);
               cur_exp = 8'h00;
            end else begin
               cur_exp = exp_q.pop_front();
            end
            fbits[0] = 1'b0;
            for (int i = 0; i < 8; i++) fbits[1 + i] = cur_exp[i];
            k = 9;
`ifdef UART_TX_PARITY_EN
            fbits[9] = (^cur_exp) ^ PODD;
            k = 10;
`endif
            for (int s = 0; s < STOP; s++) fbits[k + s] = 1'b1;
            smp[0] = tx;
         end
      end
   end

   task automatic drive_all();
      int budget;
      while (drv_q.size() > 0) begin
         budget = 0;
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = drv_q[0];
         while (!in_ready && budget < 3000) begin
            @(negedge clk);
            budget++;
         end
         if (!in_ready) begin
            chk("accept_timeout", drv_q.size(), 0);
            drv_q.delete();
         end else begin
            exp_q.push_back(drv_q.pop_front());
            acc_cyc = cyc;
            @(posedge clk);
            #1;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input int target, input int budget);
      int k = 0;
      while (frames_done < target && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk("wait_frames_done", frames_done, target);
   endtask

   task automatic wait_start(input int target, input int budget);
      int k = 0;
      while (frames_started < target && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk("wait_frames_started", frames_started, target);
   endtask

   initial begin
      int r0, busy_fall, tx_low, prev, a5_acc, rel, k;

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_tx", tx, 1'b1);
      chk("rst_busy", tx_busy, 1'b1);
      chk("rst_done", tx_done, 1'b0);
      chk("rst_ready", in_ready, 1'b1);

      // Reset release then idle: guard lasts one bit time
      reset     = 1'b1;
      r0        = cyc;
      busy_fall = -1;
      tx_low    = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) tx_low++;
         if (tx_busy === 1'b0 && busy_fall < 0) busy_fall = cyc;
      end
      chk("idle_tx_high", tx_low, 0);
      chk("guard_len", busy_fall - r0, CPB);

      // Single byte 0xA5: start one cycle after the hold write
      prev = frames_done;
      drv_q.push_back(8'hA5);
      drive_all();
      a5_acc = acc_cyc;
      wait_done(prev + 1, FRAME + 50);
      chk("a5_start_latency", last_t0 - a5_acc, 2);
      repeat (5) @(negedge clk);

      // Back-to-back: second byte offered while first is in START
      prev = frames_done;
      drv_q.push_back(8'h00);
      drive_all();
      wait_start(frames_started + 1, 50);
      repeat (3) @(negedge clk);
      chk("b2b_ready_in_start", in_ready, 1'b1);
      drv_q.push_back(8'hFF);
      drive_all();
      chk("b2b_ready_low", in_ready, 1'b0);
      wait_done(prev + 2, 2 * FRAME + 50);
      chk("b2b_zero_gap", last_gap, 0);
      repeat (5) @(negedge clk);

      // Backpressure: valid held, data changes only on accept
      prev = frames_done;
      drv_q.push_back(8'h11);
      drv_q.push_back(8'h22);
      drv_q.push_back(8'h33);
      drive_all();
      chk("bp_ready_low_hold_full", in_ready, 1'b0);
      wait_done(prev + 3, 3 * FRAME + 50);
      chk("bp_gap", last_gap, 0);
      repeat (5) @(negedge clk);

      // Randomized stream, parity-check byte first
      prev = frames_done;
      drv_q.push_back(8'h07);
      drive_all();
      for (int i = 0; i < 16; i++) begin
         drv_q.push_back(8'($urandom_range(0, 255)));
         drive_all();
         k = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 200);
         repeat (k) @(negedge clk);
      end
      wait_done(prev + 17, 17 * FRAME + 200);
      repeat (5) @(negedge clk);

      // Reset mid-frame: line forced high at once, hold discarded, guard re-runs
      drv_q.push_back(8'hC3);
      drive_all();
      wait_start(frames_started + 1, 50);
      drv_q.push_back(8'h5A);
      drive_all();
      k = 0;
      while (cyc < last_t0 + 70 && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("pre_reset_line_low", tx, 1'b0);
      #1 reset = 1'b0;
      #1;
      chk("midreset_tx", tx, 1'b1);
      chk("midreset_ready", in_ready, 1'b1);
      chk("midreset_busy", tx_busy, 1'b1);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      rel   = cyc;
      prev  = frames_done;
      drv_q.push_back(8'h96);
      drive_all();
      wait_done(prev + 1, FRAME + 100);
      chk("guard_after_reset", last_t0 - rel, CPB + 1);

      // Drain and make sure nothing stray follows
      k = 0;
      while ((in_frame || exp_q.size() != 0) && k < 2 * FRAME) begin
         @(negedge clk);
         k++;
      end
      repeat (2 * CPB) @(negedge clk);
      chk("scoreboard_empty", exp_q.size(), 0);
      chk("no_stray_frame", in_frame, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
